// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//
// Instruction-fetch controller for the 5-stage MIPS pipeline. It owns the
// word-indexed program counter that addresses the combinational instruction
// ROM and captures the returned word into the IF/ID register. It applies
// hazard stalls and jump / jr / branch redirects, and enters HALT when the PC
// runs past the end of the ROM. It also keeps saturating counters of fetched
// instructions and stall cycles.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 hold PC and IF/ID (load-use hazard)
//   jump / jump_target    J-type redirect resolved in ID
//   jr / jr_target        jump-register redirect resolved in ID
//   branch_taken / _target taken branch resolved in EX (highest priority)
//   instr_in              ROM word for pc_out (same cycle)
//   pc_out                current fetch PC (ROM address)
//   ifid_instr/_pc_next/_valid  IF/ID pipeline register
//   halted                FSM is in HALT
//   fetch_count           instructions accepted into IF/ID (saturating)
//   stall_count           stall cycles applied in RUN (saturating)

module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 32,
    parameter logic [31:0] PC_INC     = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_next,
    output logic        ifid_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    logic [1:0]  state;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_seq;
    logic        past_end;

    // Branch is the oldest instruction in flight, so it beats jr, then jump.
    always_comb begin
        redirect    = branch_taken | jr | jump;
        redirect_pc = jump_target;
        if (branch_taken) begin
            redirect_pc = branch_target;
        end else if (jr) begin
            redirect_pc = jr_target;
        end
        pc_seq   = pc_out + PC_INC;
        past_end = (pc_out >= DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_BOOT;
            pc_out       <= RESET_PC;
            ifid_instr   <= '0;
            ifid_pc_next <= '0;
            ifid_valid   <= 1'b0;
            halted       <= 1'b0;
            fetch_count  <= '0;
            stall_count  <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    if (redirect) begin
                        pc_out       <= redirect_pc;
                        ifid_instr   <= '0;
                        ifid_pc_next <= '0;
                        ifid_valid   <= 1'b0;
                    end else if (stall) begin
                        if (stall_count != '1) begin
                            stall_count <= stall_count + 32'd1;
                        end
                    end else if (past_end) begin
                        state        <= ST_HALT;
                        halted       <= 1'b1;
                        ifid_instr   <= '0;
                        ifid_pc_next <= '0;
                        ifid_valid   <= 1'b0;
                    end else begin
                        pc_out       <= pc_seq;
                        ifid_instr   <= instr_in;
                        ifid_pc_next <= pc_seq;
                        ifid_valid   <= 1'b1;
                        if (fetch_count != '1) begin
                            fetch_count <= fetch_count + 32'd1;
                        end
                    end
                end

                ST_HALT: begin
                    // IF/ID already holds the bubble loaded on HALT entry.
                    if (redirect) begin
                        pc_out <= redirect_pc;
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_next;
    logic        ifid_valid;
    logic        halted;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc_next;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .RESET_PC  (32'd0),
        .IMEM_DEPTH(32),
        .PC_INC    (32'd1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .instr_in     (instr_in),
        .pc_out       (pc_out),
        .ifid_instr   (ifid_instr),
        .ifid_pc_next (ifid_pc_next),
        .ifid_valid   (ifid_valid),
        .halted       (halted),
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
    );

    // ROM contents: word 1 is the documented test word, others are distinct.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx >= 32'd32) return 32'h0;
        if (idx == 32'd1) return 32'h0022_1800;
        return 32'hA500_0000 | (idx * 32'h0000_0111);
    endfunction

    assign instr_in = rom_word(pc_out);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, advance one clock, then pop and compare.
    task automatic step(input logic [31:0] pc, input logic v, input logic [31:0] ins,
                        input logic [31:0] pcn, input logic h);
        exp_t e;
        e.pc = pc; e.valid = v; e.instr = ins; e.pc_next = pcn; e.halted = h;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc_out",       pc_out,              e.pc);
        check("ifid_valid",   {31'd0, ifid_valid}, {31'd0, e.valid});
        check("ifid_instr",   ifid_instr,          e.instr);
        check("ifid_pc_next", ifid_pc_next,        e.pc_next);
        check("halted",       {31'd0, halted},     {31'd0, e.halted});
    endtask

    task automatic bubble(input logic [31:0] pc, input logic h);
        step(pc, 1'b0, 32'h0, 32'h0, h);
    endtask

    task automatic fetch(input logic [31:0] next_pc);
        step(next_pc, 1'b1, rom_word(next_pc - 32'd1), next_pc, 1'b0);
    endtask

    task automatic clear_redirects();
        jump = 1'b0; jr = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0;
        jump = 1'b0; jr = 1'b0; branch_taken = 1'b0;
        jump_target = 32'd0; jr_target = 32'd0; branch_target = 32'd0;

        // Reset state
        @(posedge clk); #1;
        bubble(32'd0, 1'b0);
        check("fetch_count_rst", fetch_count, 32'd0);
        check("stall_count_rst", stall_count, 32'd0);

        // BOOT cycle, then sequential fetch
        reset = 1'b0;
        bubble(32'd0, 1'b0);
        fetch(32'd1);
        fetch(32'd2);                       // ifid_instr = 0022_1800, pc_next = 2
        check("rom1_word", ifid_instr, 32'h0022_1800);
        fetch(32'd3);
        fetch(32'd4);
        check("fetch_count_seq", fetch_count, 32'd4);

        // Three-cycle stall at pc 4
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step(32'd4, 1'b1, rom_word(32'd3), 32'd4, 1'b0);
        check("stall_count_3", stall_count, 32'd3);
        check("fetch_count_stall", fetch_count, 32'd4);
        stall = 1'b0;
        fetch(32'd5);
        fetch(32'd6);

        // All redirects plus stall at pc 6: branch wins
        branch_taken = 1'b1; branch_target = 32'd20;
        jr = 1'b1; jr_target = 32'd18;
        jump = 1'b1; jump_target = 32'd7;
        stall = 1'b1;
        bubble(32'd20, 1'b0);
        clear_redirects(); stall = 1'b0;
        check("stall_count_redir", stall_count, 32'd3);
        check("fetch_count_redir", fetch_count, 32'd6);
        fetch(32'd21);                      // ROM[20]

        // Jump alone
        jump = 1'b1; jump_target = 32'd7;
        bubble(32'd7, 1'b0);
        clear_redirects();
        fetch(32'd8);

        // jr alone
        jr = 1'b1; jr_target = 32'd3;
        bubble(32'd3, 1'b0);
        clear_redirects();
        fetch(32'd4);

        // Run off the end of the ROM
        for (int p = 5; p <= 32; p++) fetch(32'(p));
        bubble(32'd32, 1'b1);
        for (int i = 0; i < 9; i++) begin
            stall = (i % 2) == 0;           // stall is ignored in HALT
            bubble(32'd32, 1'b1);
        end
        stall = 1'b0;
        check("fetch_count_halt", fetch_count, 32'd37);
        check("stall_count_halt", stall_count, 32'd3);

        // Leave HALT with jump to 0
        jump = 1'b1; jump_target = 32'd0;
        bubble(32'd0, 1'b0);
        clear_redirects();
        fetch(32'd1);

        // Jump past the end, stall there (no HALT entry), then halt
        jump = 1'b1; jump_target = 32'd32;
        bubble(32'd32, 1'b0);
        clear_redirects();
        stall = 1'b1;
        bubble(32'd32, 1'b0);
        check("stall_count_end", stall_count, 32'd4);
        stall = 1'b0;
        bubble(32'd32, 1'b1);

        // Reset while stalled in HALT
        stall = 1'b1; reset = 1'b1;
        bubble(32'd0, 1'b0);
        check("fetch_count_rst2", fetch_count, 32'd0);
        check("stall_count_rst2", stall_count, 32'd0);
        reset = 1'b0; stall = 1'b0;
        bubble(32'd0, 1'b0);                // single BOOT cycle
        fetch(32'd1);
        check("fetch_count_boot", fetch_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller for the 5-stage MIPS pipeline. Owns the program counter that addresses the combinational instruction ROM, captures the returned word into the IF/ID pipeline register, and applies stalls from the hazard unit and redirects from jump, jump-register and branch resolution. Also tracks an end-of-program halt condition and keeps two saturating performance counters for fetched instructions and stall cycles.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset.
- IMEM_DEPTH, 32, number of ROM words. PC is a word index; PCs >= IMEM_DEPTH read as 0.
- PC_INC, 32'd1, sequential PC increment, in words.
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- jump  in  1  J-type redirect resolved in ID.
- jump_target  in  32  target word index for jump.
- jr  in  1  jump-register redirect resolved in ID.
- jr_target  in  32  register value for jr.
- branch_taken  in  1  taken branch resolved in EX.
- branch_target  in  32  target word index for the branch.
- instr_in  in  32  word from instruction ROM for pc_out.
- pc_out  out  32  current fetch PC, drives the ROM address.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc_next  out  32  IF/ID PC + PC_INC, used for link and branch-offset math.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  FSM is in HALT.
- fetch_count  out  32  instructions accepted into IF/ID, saturates at 32'hFFFF_FFFF.
- stall_count  out  32  cycles with stall applied in RUN, saturating.

## Operation
- FSM states: BOOT, RUN, HALT.
- Reset (takes priority over everything):
  - state = BOOT, pc_out = RESET_PC.
  - ifid_instr = 0, ifid_pc_next = 0, ifid_valid = 0.
  - halted = 0, both counters = 0.
- BOOT: lasts exactly one cycle. PC holds, IF/ID holds the bubble, then the FSM goes to RUN.
- RUN: each cycle selects the next PC in priority order:
  - branch_taken: next PC = branch_target. This is the oldest instruction, so it wins over everything.
  - jr: next PC = jr_target.
  - jump: next PC = jump_target.
  - stall: PC holds.
  - Otherwise: next PC = pc_out + PC_INC, 32-bit wrap-around.
- Redirect (any of branch_taken, jr, jump):
  - IF/ID loads a bubble: instr = 0, valid = 0, pc_next = 0.
  - A redirect overrides a simultaneous stall.
  - fetch_count does not increment.
- Stall without redirect:
  - IF/ID holds all fields.
  - stall_count increments.
- Normal cycle:
  - IF/ID captures instr_in, pc_out + PC_INC and valid = 1.
  - fetch_count increments.
- HALT entry: in RUN, if pc_out >= IMEM_DEPTH and there is no redirect and no stall:
  - FSM goes to HALT.
  - IF/ID loads a bubble.
  - PC freezes.
- HALT:
  - halted = 1, pc_out frozen, IF/ID holds the bubble, counters frozen, stall ignored.
  - Any redirect loads its target into PC and returns the FSM to RUN. Same priority order as RUN.
- Redirect or stall while pc_out >= IMEM_DEPTH: processed as in RUN, with no HALT entry that cycle.
- Counters saturate and never wrap.

## Timing
- pc_out, all IF/ID outputs, halted and both counters are registered.
- instr_in is expected combinationally within the same cycle as pc_out.
- Fetch latency: a word addressed by pc_out in cycle t appears on ifid_instr in cycle t+1.
- Redirect latency:
  - Redirect asserted in cycle t gives pc_out = target at t+1.
  - The target instruction appears in IF/ID at t+2.
  - The t+1 IF/ID content is the bubble.
- Stall: in cycle t, PC and IF/ID are unchanged at t+1. No extra recovery cycle after stall drops.
- Reset release: first cycle BOOT with pc_out = RESET_PC; first valid IF/ID at cycle 2 after release.
- Reset asserted mid-stream (including HALT or during a stall): full reset values at the next edge. In-flight IF/ID content is discarded.

## Test plan
- Sequential fetch: release reset with ROM[1] = 32'h0022_1800.
  - After BOOT, pc_out steps 0,1,2,…
  - ifid_instr = 32'h0022_1800 with ifid_pc_next = 2 one cycle after pc_out = 1.
- Stall: assert stall for 3 cycles at pc_out = 4.
  - pc_out stays 4 and ifid_instr is held.
  - stall_count = 3, fetch_count unchanged.
  - pc_out = 5 on the first cycle after release.
- Redirect priority: at pc_out = 6, assert branch_taken (target 20), jr (target 18) and jump (target 7) together with stall.
  - pc_out = 20 next cycle, IF/ID is the bubble.
  - ifid_instr = ROM[20] one cycle later.
- Jump and jr alone:
  - jump target 7 gives pc_out = 7.
  - jr target 3 gives pc_out = 3.
  - Each produces exactly one bubble cycle (ifid_valid = 0).
- Halt: run to pc_out = 32 with no redirect.
  - halted = 1 and pc_out stays 32 for 10 cycles.
  - Then jump target 0 gives halted = 0 and pc_out = 0.
- Reset mid-stall in HALT: assert reset.
  - Next edge: pc_out = 0, ifid_valid = 0, halted = 0, counters = 0.
  - BOOT lasts exactly one cycle.
